// File: rtl/bp_fe_ras.sv
// bp_fe_ras: circular return address stack with one-cycle checkpoint restore
module bp_fe_ras #(
  parameter int vaddr_width_p = 39,
  parameter int ras_els_p = 8,
  parameter int ptr_width = $clog2(ras_els_p),
  parameter int ckpt_width_p = 2*ptr_width+1
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic push_v_i,
  input  logic [vaddr_width_p-1:0] push_addr_i,
  input  logic pop_v_i,
  output logic [vaddr_width_p-1:0] top_addr_o,
  output logic top_v_o,
  output logic [ckpt_width_p-1:0] ckpt_o,
  input  logic restore_v_i,
  input  logic [ckpt_width_p-1:0] restore_ckpt_i,
  output logic overflow_o,
  output logic underflow_o
);
  localparam logic [ptr_width:0] full_lp = (ptr_width+1)'(ras_els_p);
  logic [vaddr_width_p-1:0] mem [ras_els_p];
  logic [ptr_width-1:0] tos_r, tos_inc, tos_dec;
  logic [ptr_width:0] count_r;
  logic overflow_r, underflow_r;
  assign tos_inc = tos_r + 1'b1;
  assign tos_dec = tos_r - 1'b1;
  // restore beats push/pop; push+pop on a live stack replaces the top in place
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      tos_r <= '1;
      count_r <= '0;
      mem <= '{default: '0};
      overflow_r <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r <= 1'b0;
      underflow_r <= 1'b0;
      if (restore_v_i)
        {count_r, tos_r} <= restore_ckpt_i;
      else if (push_v_i && pop_v_i && count_r != '0)
        mem[tos_r] <= push_addr_i;
      else if (push_v_i) begin
        tos_r <= tos_inc;
        mem[tos_inc] <= push_addr_i;
        if (count_r == full_lp)
          overflow_r <= 1'b1;
        else
          count_r <= count_r + 1'b1;
      end else if (pop_v_i) begin
        if (count_r != '0) begin
          tos_r <= tos_dec;
          count_r <= count_r - 1'b1;
        end else
          underflow_r <= 1'b1;
      end
    end
  end
  assign top_addr_o = mem[tos_r];
  assign top_v_o = |count_r;
  assign ckpt_o = {count_r, tos_r};
  assign overflow_o = overflow_r;
  assign underflow_o = underflow_r;
endmodule

// File: tb/tb_bp_fe_ras.sv
// tb_bp_fe_ras: directed vector table plus hand sequences for the 4-entry RAS
module tb_bp_fe_ras;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic push_v = 1'b0;
  logic pop_v = 1'b0;
  logic restore_v = 1'b0;
  logic [38:0] push_addr = '0;
  logic [4:0] restore_ckpt = '0;
  logic [38:0] top_addr;
  logic top_v;
  logic [4:0] ckpt;
  logic overflow, underflow;
  int checks = 0;
  int failures = 0;

  bp_fe_ras #(.vaddr_width_p(39), .ras_els_p(4)) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .push_v_i(push_v),
    .push_addr_i(push_addr),
    .pop_v_i(pop_v),
    .top_addr_o(top_addr),
    .top_v_o(top_v),
    .ckpt_o(ckpt),
    .restore_v_i(restore_v),
    .restore_ckpt_i(restore_ckpt),
    .overflow_o(overflow),
    .underflow_o(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rn, push, pop, rest;
    logic [38:0] addr;
    logic [4:0] rck;
    logic [38:0] top;
    logic v;
    logic [4:0] ck;
    logic ovf, unf;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rn, input logic push, input logic pop, input logic rest,
                       input logic [38:0] addr, input logic [4:0] rck);
    @(negedge clk);
    reset_n = rn;
    push_v = push;
    pop_v = pop;
    restore_v = rest;
    push_addr = addr;
    restore_ckpt = rck;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rn, input logic push, input logic pop, input logic rest,
                     input logic [38:0] addr, input logic [4:0] rck, input logic [38:0] top,
                     input logic v, input logic [4:0] ck, input logic ovf, input logic unf);
    vec_t e;
    e.rn = rn; e.push = push; e.pop = pop; e.rest = rest; e.addr = addr; e.rck = rck;
    e.top = top; e.v = v; e.ck = ck; e.ovf = ovf; e.unf = unf;
    vt.push_back(e);
  endtask

  task automatic chk_out(input string tag, input logic [38:0] top, input logic v,
                         input logic [4:0] ck, input logic ovf, input logic unf);
    chk({tag, ".top"}, 64'(top_addr), 64'(top));
    chk({tag, ".v"}, 64'(top_v), 64'(v));
    chk({tag, ".ckpt"}, 64'(ckpt), 64'(ck));
    chk({tag, ".ovf"}, 64'(overflow), 64'(ovf));
    chk({tag, ".unf"}, 64'(underflow), 64'(unf));
  endtask

  logic [4:0] sample;

  initial begin
    //  rn push pop rest addr       rck        top        v  ckpt       ovf unf
    add(1, 1, 0, 0, 39'h1000, 5'h0, 39'h1000, 1, 5'b001_00, 0, 0);
    add(1, 1, 0, 0, 39'h2000, 5'h0, 39'h2000, 1, 5'b010_01, 0, 0);
    add(1, 1, 0, 0, 39'h3000, 5'h0, 39'h3000, 1, 5'b011_10, 0, 0);
    add(1, 0, 1, 0, 39'h0,    5'h0, 39'h2000, 1, 5'b010_01, 0, 0);
    add(1, 0, 1, 0, 39'h0,    5'h0, 39'h1000, 1, 5'b001_00, 0, 0);
    add(1, 0, 1, 0, 39'h0,    5'h0, 39'h0,    0, 5'b000_11, 0, 0);
    add(1, 0, 1, 0, 39'h0,    5'h0, 39'h0,    0, 5'b000_11, 0, 1);
    add(1, 0, 0, 0, 39'h0,    5'h0, 39'h0,    0, 5'b000_11, 0, 0);
    add(1, 1, 0, 0, 39'h10,   5'h0, 39'h10,   1, 5'b001_00, 0, 0);
    add(1, 1, 0, 0, 39'h20,   5'h0, 39'h20,   1, 5'b010_01, 0, 0);
    add(1, 1, 0, 0, 39'h30,   5'h0, 39'h30,   1, 5'b011_10, 0, 0);
    add(1, 1, 0, 0, 39'h40,   5'h0, 39'h40,   1, 5'b100_11, 0, 0);
    add(1, 1, 0, 0, 39'h50,   5'h0, 39'h50,   1, 5'b100_00, 1, 0);
    add(1, 0, 1, 0, 39'h0,    5'h0, 39'h40,   1, 5'b011_11, 0, 0);
    add(1, 0, 1, 0, 39'h0,    5'h0, 39'h30,   1, 5'b010_10, 0, 0);
    add(1, 0, 1, 0, 39'h0,    5'h0, 39'h20,   1, 5'b001_01, 0, 0);
    add(1, 0, 1, 0, 39'h0,    5'h0, 39'h50,   0, 5'b000_00, 0, 0);
    add(0, 0, 0, 0, 39'h0,    5'h0, 39'h0,    0, 5'b000_11, 0, 0);
    add(1, 1, 0, 0, 39'h100,  5'h0, 39'h100,  1, 5'b001_00, 0, 0);
    add(1, 1, 0, 0, 39'h200,  5'h0, 39'h200,  1, 5'b010_01, 0, 0);
    add(1, 1, 0, 0, 39'h300,  5'h0, 39'h300,  1, 5'b011_10, 0, 0);
    add(1, 0, 1, 0, 39'h0,    5'h0, 39'h200,  1, 5'b010_01, 0, 0);
    add(1, 0, 1, 0, 39'h0,    5'h0, 39'h100,  1, 5'b001_00, 0, 0);
    add(1, 0, 0, 1, 39'h0, 5'b010_01, 39'h200, 1, 5'b010_01, 0, 0);
    add(1, 1, 1, 0, 39'h900,  5'h0, 39'h900,  1, 5'b010_01, 0, 0);
    add(1, 0, 1, 0, 39'h0,    5'h0, 39'h100,  1, 5'b001_00, 0, 0);
    add(1, 0, 1, 0, 39'h0,    5'h0, 39'h0,    0, 5'b000_11, 0, 0);
    add(1, 1, 1, 0, 39'h900,  5'h0, 39'h900,  1, 5'b001_00, 0, 0);
    add(1, 1, 0, 1, 39'hABC, 5'b000_11, 39'h0, 0, 5'b000_11, 0, 0);
    add(1, 0, 0, 1, 39'h0, 5'b010_01, 39'h900, 1, 5'b010_01, 0, 0);
    add(1, 1, 1, 1, 39'hDEF, 5'b001_00, 39'h900, 1, 5'b001_00, 0, 0);
    add(0, 1, 0, 0, 39'h777,  5'h0, 39'h0,    0, 5'b000_11, 0, 0);

    drive(0, 0, 0, 0, 39'h0, 5'h0);
    drive(0, 0, 0, 0, 39'h0, 5'h0);
    drive(1, 0, 0, 0, 39'h0, 5'h0);
    chk_out("reset", 39'h0, 1'b0, 5'b000_11, 1'b0, 1'b0);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rn, vt[i].push, vt[i].pop, vt[i].rest, vt[i].addr, vt[i].rck);
      chk_out($sformatf("vec%0d", i), vt[i].top, vt[i].v, vt[i].ck, vt[i].ovf, vt[i].unf);
    end

    drive(1, 1, 0, 0, 39'hAAA, 5'h0);
    drive(1, 1, 0, 0, 39'hBBB, 5'h0);
    sample = ckpt;
    chk("seq.sample", 64'(sample), 64'(5'b010_01));
    @(negedge clk);
    push_v = 1'b1;
    push_addr = 39'hCCC;
    #1;
    chk("seq.no_comb_top", 64'(top_addr), 64'(39'hBBB));
    chk("seq.no_comb_ckpt", 64'(ckpt), 64'(5'b010_01));
    @(posedge clk);
    #1;
    chk("seq.push_top", 64'(top_addr), 64'(39'hCCC));
    drive(1, 0, 0, 1, 39'h0, sample);
    chk_out("seq.restore", 39'hBBB, 1'b1, 5'b010_01, 1'b0, 1'b0);
    drive(1, 0, 1, 0, 39'h0, 5'h0);
    chk_out("seq.pop_after_restore", 39'hAAA, 1'b1, 5'b001_00, 1'b0, 1'b0);
    drive(1, 0, 0, 0, 39'h0, 5'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
